// File: rtl/mac_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_loader
//  Description : Serial-to-parallel operand packer for the 62-lane
//                sign-magnitude MAC. Collects (activation, weight) byte
//                pairs one per handshake into packed lane buses and hands
//                the completed vector over with a valid/ready handshake.
//                Optional feature macro: LOADER_ZERO_PAD_EN (in_last closes
//                a short vector, upper lanes stay zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_loader #(
    parameter int LANES = 62,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_w,
    input  logic                   in_last,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [LANES*WIDTH-1:0] vec_a,
    output logic [LANES*WIDTH-1:0] vec_w,
    output logic [5:0]             vec_lanes
);

    localparam int              IDX_W      = $clog2(LANES);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_in_ready;
    logic                   r_vec_valid;
    logic [LANES*WIDTH-1:0] r_vec_a;
    logic [LANES*WIDTH-1:0] r_vec_w;
    logic [5:0]             r_vec_lanes;

    logic                   w_accept;
    logic                   w_close;
    logic [5:0]             w_lanes_next;

    // A pair is taken only while filling and advertising ready.
    assign w_accept     = (r_state == S_FILL) && r_in_ready && in_valid;
    assign w_lanes_next = 6'(r_idx) + 6'd1;

`ifdef LOADER_ZERO_PAD_EN
    // A vector closes on the last lane or when upstream flags a short vector.
    assign w_close = (r_idx == c_LAST_IDX) || in_last;
`else
    // Every vector is exactly LANES pairs; in_last has no effect.
    logic w_unused_in_last;
    assign w_unused_in_last = in_last;
    assign w_close          = (r_idx == c_LAST_IDX);
`endif

    // Fill/handoff state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vec_a     <= '0;
            r_vec_w     <= '0;
            r_vec_lanes <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    // Ready rises on the first edge after reset release.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        // Bytes are stored bit-exact (0x80 stays 0x80).
                        r_vec_a[r_idx*WIDTH +: WIDTH] <= in_a;
                        r_vec_w[r_idx*WIDTH +: WIDTH] <= in_w;
                        if (w_close) begin
                            r_state     <= S_FULL;
                            r_in_ready  <= 1'b0;
                            r_vec_valid <= 1'b1;
                            r_vec_lanes <= w_lanes_next;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    // Hold everything until the MAC side takes the vector;
                    // clearing here keeps unloaded lanes of the next vector zero.
                    if (vec_ready) begin
                        r_state     <= S_FILL;
                        r_idx       <= '0;
                        r_in_ready  <= 1'b1;
                        r_vec_valid <= 1'b0;
                        r_vec_a     <= '0;
                        r_vec_w     <= '0;
                        r_vec_lanes <= '0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign vec_valid = r_vec_valid;
    assign vec_a     = r_vec_a;
    assign vec_w     = r_vec_w;
    assign vec_lanes = r_vec_lanes;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_operand_loader
//  Description : Scoreboard bench for mac_operand_loader. Stimulus pushes the
//                expected packed vector when its closing pair is issued; a
//                monitor pops and compares each time vec_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_operand_loader;

    localparam int LANES = 62;
    localparam int WIDTH = 8;
    localparam int BW    = LANES * WIDTH;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          vec_ready = 1'b0;
    logic [7:0]    in_a      = '0;
    logic [7:0]    in_w      = '0;
    logic          in_ready;
    logic          vec_valid;
    logic [BW-1:0] vec_a;
    logic [BW-1:0] vec_w;
    logic [5:0]    vec_lanes;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] w;
        logic [5:0]    n;
    } exp_t;

    exp_t       q[$];
    exp_t       last_exp;
    exp_t       mon_e;
    logic [7:0] m_a[LANES];
    logic [7:0] m_w[LANES];
    int         m_idx     = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         g_put_cyc = 0;
    int         t0        = 0;
    logic       prev_v    = 1'b0;

    mac_operand_loader #(.LANES(LANES), .WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .in_last   (in_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_a     (vec_a),
        .vec_w     (vec_w),
        .vec_lanes (vec_lanes)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk(name, BW'(act), BW'(exp));
    endtask

    function automatic void model_clear();
        for (int i = 0; i < LANES; i++) begin
            m_a[i] = 8'h00;
            m_w[i] = 8'h00;
        end
        m_idx = 0;
    endfunction

    function automatic void model_push();
        exp_t e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            e.a[i*WIDTH +: WIDTH] = m_a[i];
            e.w[i*WIDTH +: WIDTH] = m_w[i];
        end
        e.n = 6'(m_idx);
        q.push_back(e);
        last_exp = e;
        model_clear();
    endfunction

    // Called at a negedge; presents one pair for exactly one accepted cycle.
    task automatic put(input logic [7:0] a, input logic [7:0] w, input logic last);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: in_ready got 0 expected 1");
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_w      = w;
        in_last   = last;
        g_put_cyc = cyc;
        m_a[m_idx] = a;
        m_w[m_idx] = w;
        m_idx++;
`ifdef LOADER_ZERO_PAD_EN
        if (m_idx == LANES || last) model_push();
`else
        if (m_idx == LANES) model_push();
`endif
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handoff();
        int t;
        t = 0;
        while (!vec_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("wait_vec_valid", BW'(vec_valid), BW'(1'b1));
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
    endtask

    // Monitor: compare each newly presented vector against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (vec_valid && !prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: vec_valid got 1 expected 0 (no vector pending)");
                end else begin
                    mon_e = q.pop_front();
                    chk("mon_vec_a", vec_a, mon_e.a);
                    chk("mon_vec_w", vec_w, mon_e.w);
                    chk("mon_vec_lanes", BW'(vec_lanes), BW'(mon_e.n));
                end
            end
            prev_v = vec_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        // Reset state
        #12;
        chk("rst_in_ready", BW'(in_ready), BW'(1'b0));
        chk("rst_vec_valid", BW'(vec_valid), BW'(1'b0));
        chk("rst_vec_a", vec_a, '0);
        chk("rst_vec_w", vec_w, '0);
        chk("rst_vec_lanes", BW'(vec_lanes), BW'(6'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", BW'(in_ready), BW'(1'b1));

        // Full vector, back to back, vec_ready low
        for (int i = 0; i < LANES - 1; i++) begin
            put(8'(i), 8'(8'h80 | i), 1'b0);
            if (i == 0) t0 = g_put_cyc;
        end
        chk("valid_before_62nd", BW'(vec_valid), BW'(1'b0));
        put(8'd61, 8'hBD, 1'b0);
        chk("valid_after_62nd", BW'(vec_valid), BW'(1'b1));
        chk("latency_full", BW'(cyc - t0), BW'(62));
        chk8("full_lane0_a", vec_a[7:0], 8'h00);
        chk8("full_lane61_a", vec_a[495:488], 8'h3D);
        chk8("full_lane1_w", vec_w[15:8], 8'h81);
        chk("full_lanes", BW'(vec_lanes), BW'(6'd62));
        repeat (20) begin
            @(negedge clk);
            chk("hold_in_ready", BW'(in_ready), BW'(1'b0));
            chk("hold_vec_a", vec_a, last_exp.a);
            chk("hold_vec_w", vec_w, last_exp.w);
        end

        // Handoff and restart
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        chk("ho_vec_valid", BW'(vec_valid), BW'(1'b0));
        chk("ho_vec_a", vec_a, '0);
        chk("ho_vec_w", vec_w, '0);
        chk("ho_vec_lanes", BW'(vec_lanes), BW'(6'd0));
        chk("ho_in_ready", BW'(in_ready), BW'(1'b1));
        put(8'h7F, 8'h7F, 1'b0);
        chk("restart_a", vec_a, BW'(8'h7F));
        chk("restart_w", vec_w, BW'(8'h7F));
        for (int i = 1; i < LANES; i++) put(8'(i * 2), 8'(i ^ 8'h55), 1'b0);
        handoff();

        // Upstream gaps: in_valid toggles every cycle
        for (int i = 0; i < LANES; i++) begin
            put(8'(i), 8'(8'h80 | i), 1'b0);
            if (i == 0) t0 = g_put_cyc;
            if (i != LANES - 1) @(negedge clk);
        end
        chk("gap_vec_valid", BW'(vec_valid), BW'(1'b1));
        chk("latency_gaps", BW'(cyc - t0), BW'(123));
        chk8("gap_lane61_a", vec_a[495:488], 8'h3D);
        chk8("gap_lane1_w", vec_w[15:8], 8'h81);
        handoff();

        // Reset mid-vector
        for (int i = 0; i < 30; i++) put(8'(8'hA0 + i), 8'(8'h40 + i), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", BW'(in_ready), BW'(1'b0));
        chk("arst_vec_valid", BW'(vec_valid), BW'(1'b0));
        chk("arst_vec_a", vec_a, '0);
        chk("arst_vec_w", vec_w, '0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < LANES; i++) put(8'(8'hFF - i), 8'(i * 3), 1'b0);
        handoff();

        // Short vector with in_last on the 5th pair
        for (int i = 0; i < 5; i++) put(8'h85, 8'h03, (i == 4));
`ifdef LOADER_ZERO_PAD_EN
        chk("zp_vec_valid", BW'(vec_valid), BW'(1'b1));
        chk("zp_vec_lanes", BW'(vec_lanes), BW'(6'd5));
        chk8("zp_lane5_a", vec_a[47:40], 8'h00);
        handoff();
`else
        chk("nozp_vec_valid", BW'(vec_valid), BW'(1'b0));
        chk("nozp_in_ready", BW'(in_ready), BW'(1'b1));
        for (int i = 5; i < LANES; i++) put(8'h11, 8'h22, 1'b0);
        chk("nozp_vec_lanes", BW'(vec_lanes), BW'(6'd62));
        handoff();
`endif

        // Negative zero stored unchanged
        put(8'h80, 8'h80, 1'b0);
        chk8("negz_lane0_a_fill", vec_a[7:0], 8'h80);
        for (int i = 1; i < LANES; i++) put(8'(i), 8'(i), 1'b0);
        chk8("negz_lane0_a", vec_a[7:0], 8'h80);
        chk8("negz_lane0_w", vec_w[7:0], 8'h80);
        handoff();

        @(negedge clk);
        chk("scoreboard_empty", BW'(q.size()), BW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
